// File: rtl/screen_fill_engine_pkg.sv
// Shared constants, FSM encoding and VRAM address helper for the screen fill engine.
package screen_fill_engine_pkg;

    localparam int WORDS_PER_ROW = 32;
    localparam int ROWS          = 256;
    localparam int ADDR_W        = $clog2(WORDS_PER_ROW * ROWS);
    localparam int COL_W         = 5;
    localparam int ROW_W         = 8;
    localparam int DATA_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    function automatic logic [ADDR_W-1:0] vram_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/screen_fill_engine_fill_rect_counter.sv
// Row/column walker over an inclusive rectangle; latches its bounds on load.
module fill_rect_counter
    import screen_fill_engine_pkg::*;
(
    input  logic             clk,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [COL_W-1:0] x0_i,
    input  logic [COL_W-1:0] x1_i,
    input  logic [ROW_W-1:0] y0_i,
    input  logic [ROW_W-1:0] y1_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] x0_q, x0_d;
    logic [COL_W-1:0] x1_q, x1_d;
    logic [ROW_W-1:0] y1_q, y1_d;

    assign last_o = (row_q == y1_q) && (col_q == x1_q);
    assign row_o  = row_q;
    assign col_o  = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        x0_d  = x0_q;
        x1_d  = x1_q;
        y1_d  = y1_q;
        if (load_i) begin
            row_d = y0_i;
            col_d = x0_i;
            x0_d  = x0_i;
            x1_d  = x1_i;
            y1_d  = y1_i;
        end else if (advance_i && !last_o) begin
            // The final cell leaves the counters parked so nothing wraps past y1/x1.
            if (col_q == x1_q) begin
                col_d = x0_q;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        row_q <= row_d;
        col_q <= col_d;
        x0_q  <= x0_d;
        x1_q  <= x1_d;
        y1_q  <= y1_d;
    end

endmodule

// File: rtl/screen_fill_engine.sv
// Owns the VRAM write port: CPU stores take priority, the rectangle filler uses idle cycles.
module screen_fill_engine
    import screen_fill_engine_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_in,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              start,
    input  logic [15:0]       pattern,
    input  logic              invert_odd,
    input  logic [4:0]        x0,
    input  logic [4:0]        x1,
    input  logic [7:0]        y0,
    input  logic [7:0]        y1,
    output logic              busy,
    output logic              done,
    output logic [15:0]       screen_in,
    output logic              screen_load,
    output logic [ADDR_W-1:0] screen_address
);

    fill_state_e state_q, state_d;

    logic [15:0]       pattern_q, pattern_d;
    logic              invert_q, invert_d;
    logic              cnt_load, cnt_adv, cnt_last;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;

    logic              wr_en;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] wr_addr;

    logic [15:0]       screen_in_q;
    logic              screen_load_q;
    logic [ADDR_W-1:0] screen_address_q;

    fill_rect_counter u_counter (
        .clk       (clk),
        .load_i    (cnt_load),
        .advance_i (cnt_adv),
        .x0_i      (x0),
        .x1_i      (x1),
        .y0_i      (y0),
        .y1_i      (y1),
        .row_o     (row),
        .col_o     (col),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_adv   = 1'b0;
        pattern_d = pattern_q;
        invert_d  = invert_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_load  = 1'b1;
                    pattern_d = pattern;
                    invert_d  = invert_odd;
                    state_d   = ((x1 < x0) || (y1 < y0)) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (!cpu_load) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write arbitration: a CPU store preempts the engine, which simply holds its position.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = cpu_in;
        wr_addr = cpu_address;
        if (cpu_load) begin
            wr_en = 1'b1;
        end else if (state_q == ST_FILL) begin
            wr_en   = 1'b1;
            wr_data = (invert_q && row[0]) ? ~pattern_q : pattern_q;
            wr_addr = vram_addr(row, col);
        end
    end

    always_ff @(posedge clk) begin
        pattern_q <= pattern_d;
        invert_q  <= invert_d;
        if (reset) begin
            state_q          <= ST_IDLE;
            screen_load_q    <= 1'b0;
            screen_in_q      <= 16'd0;
            screen_address_q <= '0;
        end else begin
            state_q       <= state_d;
            screen_load_q <= wr_en;
            if (wr_en) begin
                screen_in_q      <= wr_data;
                screen_address_q <= wr_addr;
            end
        end
    end

    assign busy           = (state_q == ST_FILL);
    assign done           = (state_q == ST_DONE);
    assign screen_in      = screen_in_q;
    assign screen_load    = screen_load_q;
    assign screen_address = screen_address_q;

endmodule

// File: tb/tb_screen_fill_engine.sv
// Scoreboard bench for screen_fill_engine: expected VRAM writes are queued, a monitor checks them.
module tb_screen_fill_engine;
    import screen_fill_engine_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       cpu_in = '0;
    logic              cpu_load = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic              start = 1'b0;
    logic [15:0]       pattern = '0;
    logic              invert_odd = 1'b0;
    logic [4:0]        x0 = '0, x1 = '0;
    logic [7:0]        y0 = '0, y1 = '0;
    logic              busy, done, screen_load;
    logic [15:0]       screen_in;
    logic [ADDR_W-1:0] screen_address;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, wr_cnt = 0, last_wr_cyc = -1;
    int t0 = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    wr_t exp_q[$];

    screen_fill_engine dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_in         (cpu_in),
        .cpu_load       (cpu_load),
        .cpu_address    (cpu_address),
        .start          (start),
        .pattern        (pattern),
        .invert_odd     (invert_odd),
        .x0             (x0),
        .x1             (x1),
        .y0             (y0),
        .y1             (y1),
        .busy           (busy),
        .done           (done),
        .screen_in      (screen_in),
        .screen_load    (screen_load),
        .screen_address (screen_address)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (screen_load === 1'b1) begin
            wr_t e;
            wr_cnt++;
            last_wr_cyc = cyc;
            last_addr = screen_address;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(screen_address), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(screen_address), 32'(e.addr));
                check("wr_data", 32'(screen_in), 32'(e.data));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy !== 1'b0) check("busy_during_done", 32'(busy), 32'd0);
        end
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [15:0] data);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_rect(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [15:0] pat, input logic inv);
        for (int r = ay0; r <= ay1; r++)
            for (int c = ax0; c <= ax1; c++)
                push(r * 32 + c, (inv && (r % 2 == 1)) ? ~pat : pat);
    endtask

    task automatic fill_start(input int ax0, input int ax1, input int ay0, input int ay1,
                              input logic [15:0] pat, input logic inv);
        done_cnt = 0;
        busy_cnt = 0;
        x0 = 5'(ax0); x1 = 5'(ax1); y0 = 8'(ay0); y1 = 8'(ay1);
        pattern = pat;
        invert_odd = inv;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) break;
        end
        @(posedge clk);
        #1;
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Fill latency: done lands words+1 edges after the start cycle (words+2 cycles inclusive).
    task automatic check_fill_end(input string name, input int words, input int stalls);
        repeat (3) tick();
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_done_latency"}, 32'(done_cyc - t0), 32'(words + stalls + 1));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(words + stalls));
        if (words > 0) check({name, "_done_with_last_write"}, 32'(last_wr_cyc), 32'(done_cyc));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int wr_before;
        repeat (2) tick();
        check("rst_load", 32'(screen_load), 32'd0);
        check("rst_in", 32'(screen_in), 32'd0);
        check("rst_addr", 32'(screen_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Plain CPU store passes straight through one cycle later.
        push(5, 16'hA5A5);
        cpu_load = 1'b1; cpu_address = 13'h0005; cpu_in = 16'hA5A5;
        tick();
        cpu_load = 1'b0;
        check("cpu_busy", 32'(busy), 32'd0);
        check("cpu_done", 32'(done), 32'd0);
        repeat (2) tick();
        check("cpu_queue_empty", 32'(exp_q.size()), 32'd0);

        push_rect(2, 3, 1, 2, 16'hFFFF, 1'b0);
        fill_start(2, 3, 1, 2, 16'hFFFF, 1'b0);
        wait_done(50);
        check_fill_end("rect", 4, 0);
        check("rect_last_addr", 32'(last_addr), 32'd67);

        push_rect(2, 3, 1, 2, 16'h00FF, 1'b1);
        fill_start(2, 3, 1, 2, 16'h00FF, 1'b1);
        wait_done(50);
        check_fill_end("checker", 4, 0);

        // CPU store on the second fill cycle stalls the engine by one cycle.
        push(34, 16'h5A5A);
        push(100, 16'h1234);
        push(35, 16'h5A5A);
        push(66, 16'h5A5A);
        push(67, 16'h5A5A);
        fill_start(2, 3, 1, 2, 16'h5A5A, 1'b0);
        tick();
        cpu_load = 1'b1; cpu_address = 13'd100; cpu_in = 16'h1234;
        tick();
        cpu_load = 1'b0;
        wait_done(50);
        check_fill_end("stall", 4, 1);

        wr_before = wr_cnt;
        fill_start(5, 4, 0, 0, 16'hBEEF, 1'b0);
        wait_done(50);
        check_fill_end("reject", 0, 0);
        check("reject_no_writes", 32'(wr_cnt - wr_before), 32'd0);

        // A second start mid-fill, with changed operands, must not affect the running fill.
        push_rect(0, 1, 0, 0, 16'h1111, 1'b0);
        fill_start(0, 1, 0, 0, 16'h1111, 1'b0);
        start = 1'b1; x0 = 5'd10; x1 = 5'd10; y0 = 8'd5; y1 = 8'd5;
        pattern = 16'hEEEE; invert_odd = 1'b1;
        tick();
        start = 1'b0;
        wait_done(50);
        check_fill_end("restart_ignored", 2, 0);

        // Full-screen fill aborted by reset after 1000 writes.
        push_rect(0, 31, 0, 31, 16'hC3C3, 1'b1);
        while (exp_q.size() > 1000) void'(exp_q.pop_back());
        fill_start(0, 31, 0, 255, 16'hC3C3, 1'b1);
        repeat (1000) tick();
        reset = 1'b1;
        tick();
        check("abort_load", 32'(screen_load), 32'd0);
        check("abort_in", 32'(screen_in), 32'd0);
        check("abort_addr", 32'(screen_address), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wr_before = wr_cnt;
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_more_writes", 32'(wr_cnt - wr_before), 32'd0);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        push_rect(0, 31, 0, 255, 16'h0F0F, 1'b1);
        fill_start(0, 31, 0, 255, 16'h0F0F, 1'b1);
        wait_done(9000);
        check_fill_end("full", 8192, 0);
        check("full_last_addr", 32'(last_addr), 32'd8191);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
